mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle, parametrised multiply/divide unit that extends the pipeline's single-cycle ALU with MIPS MULT/MULTU/DIV/DIVU and architectural HI/LO registers. It sits beside the ALU in the EX stage. While an operation is running it raises `busy` so the hazard unit can stall any dependent MFHI/MFLO. Results are committed to HI/LO and flagged with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request an operation; accepted only when `busy`=0
- `mdOp`  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- `mdInA`  input  WIDTH  multiplicand / dividend
- `mdInB`  input  WIDTH  multiplier / divisor
- `hiWe`, `loWe`  input  1 each  MTHI / MTLO write enables
- `wrData`  input  WIDTH  data for MTHI / MTLO
- `busy`  output  1  operation in progress
- `done`  output  1  one-cycle pulse when HI/LO have been updated by an operation
- `hiOut`, `loOut`  output  WIDTH  architectural HI and LO

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on `start`. On that edge, latch `mdOp`, latch the operand magnitudes, and latch the sign flags. Signed ops take the absolute value; unsigned ops pass operands through.
  - RUN lasts exactly WIDTH cycles under a down-counter (WIDTH-1 down to 0). Each cycle performs one radix-2 step.
  - RUN -> FIX when the counter reaches 0.
  - FIX -> IDLE unconditionally.
- Multiply: shift-add over a 2·WIDTH accumulator.
  - Signed: negate the product iff the operand signs differ.
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring algorithm.
  - LO = quotient, HI = remainder.
  - Signed: negate the quotient iff the signs differ; the remainder takes the sign of the dividend.
  - Signed −2^(W−1) / −1 yields LO = 0x8000_0000 and HI = 0 (falls out of the magnitude path; no special case).
  - Divide by zero (any signedness): LO = all ones, HI = raw `mdInA`. No exception is raised.
- HI/LO writes:
  - `hiWe`/`loWe` write `wrData` at the edge only when `busy`=0.
  - Writes are ignored while `busy`=1. The hazard unit guarantees none are issued then.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- Simultaneous `start` and `hiWe`/`loWe` in IDLE: both take effect. The later FIX overwrites HI/LO.
- `hiOut`/`loOut` hold their last committed values throughout RUN. Intermediate accumulator state is never visible.
- All arithmetic is modulo 2^WIDTH per register. Sign fix-ups use two's-complement negation of the full-width fields.

## Timing
- Reset (async, any state):
  - FSM -> IDLE.
  - `busy`=0, `done`=0, `hiOut`=0, `loOut`=0, counter=0.
  - An in-flight operation is discarded and HI/LO stay 0.
- Start edge E0 → `busy`=1 from after E0.
- RUN edges: E1..EW.
- FIX edge E(W+1): HI/LO are committed, `busy` drops to 0 and `done`=1 for exactly one cycle after this edge.
- Latency: W+1 cycles from the accepting edge to the result (33 for WIDTH=32). Throughput: one operation per W+2 cycles.
- `busy` and `done` are registered outputs. There is no combinational path from inputs to outputs.
- A new `start` may be presented in the cycle `done`=1 and is accepted at the next edge.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF (WIDTH=32) -> after 33 cycles: HI=0xFFFF_FFFE, LO=0x0000_0001, `done` high for one cycle, `busy` high for exactly 33 cycles.
- MULT −3 × 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. DIV −7 / 2 -> LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- DIVU 100 / 0 -> LO=0xFFFF_FFFF, HI=100. DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- `start` DIVU 10/3 then pulse `start` and `loWe` (wrData=0x1234) mid-RUN -> both ignored. Result LO=3, HI=1, committed once. MTLO 0x1234 in IDLE -> `loOut`=0x1234 next cycle.
- Assert `rst` at cycle 10 of a MULT -> `busy`, `done`, `hiOut` and `loOut` go to 0 immediately (asynchronously). After release, a new MULTU 6×7 returns LO=42, HI=0.
- Back-to-back: MULTU 2×3 with a new `start` (DIVU 9/4) asserted in the `done` cycle -> first LO=6. The second operation is accepted on the next edge and yields LO=2, HI=1 after a further 33 cycles. Repeat with WIDTH=8 to confirm 9-cycle latency.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit with architectural HI/LO.
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start, mdOp      request an op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), taken when idle
//   mdInA, mdInB     multiplicand/dividend, multiplier/divisor
//   hiWe, loWe       MTHI/MTLO write enables (honoured only when idle), wrData the value
//   busy, done       operation in progress / one-cycle completion pulse (registered)
//   hiOut, loOut     architectural HI and LO
// Each operation runs WIDTH radix-2 steps on magnitudes, then a fix-up cycle applies
// signs and commits HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] mdInA,
  input  logic [WIDTH-1:0] mdInB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;      // negate product / quotient
  logic               rneg_q, rneg_d;    // negate remainder (dividend sign)
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // addend for multiply, divisor for divide
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b, addend, quo, rem;
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;

  // Operand conditioning and one radix-2 step of each algorithm.
  always_comb begin
    sgn_a  = mdOp[0] & mdInA[WIDTH-1];
    sgn_b  = mdOp[0] & mdInB[WIDTH-1];
    mag_a  = sgn_a ? -mdInA : mdInA;
    mag_b  = sgn_b ? -mdInB : mdInB;

    // Shift-add: accumulator holds {partial product, remaining multiplier bits}.
    addend   = acc_q[0] ? opnd_q : '0;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_step = {add_sum, acc_q[WIDTH-1:1]};

    // Restoring division: accumulator holds {remainder, dividend/quotient bits}.
    // A non-negative trial difference always fits in WIDTH bits, so diff[WIDTH]
    // is a clean borrow flag.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd_q};
    div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    raw_a_d  = raw_a_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // busy is low exactly in IDLE, so MTHI/MTLO are only honoured here.
        if (hiWe) hi_d = wrData;
        if (loWe) lo_d = wrData;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = mdOp[1];
          neg_d    = sgn_a ^ sgn_b;
          rneg_d   = sgn_a;
          div0_d   = (mdInB == '0);
          raw_a_d  = mdInA;
          if (mdOp[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = rneg_q ? -rem : rem;
          lo_d = neg_q  ? -quo : quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      raw_a_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      raw_a_q  <= raw_a_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hiOut = hi_q;
  assign loOut = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hiWe, loWe;
  logic [1:0]  mdOp;
  logic [31:0] mdInA, mdInB, wrData, hiOut, loOut;
  logic        busy, done;

  logic        start8, hiWe8, loWe8;
  logic [1:0]  mdOp8;
  logic [7:0]  mdInA8, mdInB8, wrData8, hiOut8, loOut8;
  logic        busy8, done8;

  int vectors = 0;
  int miscompares = 0;
  int lat, bcnt, e;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mdOp(mdOp), .mdInA(mdInA), .mdInB(mdInB),
    .hiWe(hiWe), .loWe(loWe), .wrData(wrData), .busy(busy), .done(done),
    .hiOut(hiOut), .loOut(loOut)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mdOp(mdOp8), .mdInA(mdInA8), .mdInB(mdInB8),
    .hiWe(hiWe8), .loWe(loWe8), .wrData(wrData8), .busy(busy8), .done(done8),
    .hiOut(hiOut8), .loOut(loOut8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op, wait for the accepting edge, then count edges until done.
  // lat = edges after the accepting edge up to and including the done edge.
  // cnt = cycles sampled with busy high, starting right after the accepting edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int cnt);
    mdOp = op; mdInA = a; mdInB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    cnt = busy ? 1 : 0;
    while (!done && l < 100) begin
      @(posedge clk); #1;
      l++;
      if (busy) cnt++;
    end
  endtask

  task automatic do_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int l);
    mdOp8 = op; mdInA8 = a; mdInB8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    l = 0;
    while (!done8 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0; mdOp = 2'b00;
    mdInA = '0; mdInB = '0; wrData = '0;
    start8 = 1'b0; hiWe8 = 1'b0; loWe8 = 1'b0; mdOp8 = 2'b00;
    mdInA8 = '0; mdInB8 = '0; wrData8 = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hiOut, loOut}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max x max
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy_cycles", 64'(bcnt), 64'd33);
    check("multu_hilo", {hiOut, loOut}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    check("multu_done_pulse", 64'(done), 64'd0);

    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    check("mult_neg3x7", {hiOut, loOut}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("div_neg7by2", {hiOut, loOut}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b10, 32'd100, 32'd0, lat, bcnt);
    check("divu_by0", {hiOut, loOut}, 64'h0000_0064_FFFF_FFFF);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
    check("div_by0_signed", {hiOut, loOut}, 64'hFFFF_FFF9_FFFF_FFFF);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check("div_min_by_m1", {hiOut, loOut}, 64'h0000_0000_8000_0000);
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    check("div_7by_neg2", {hiOut, loOut}, 64'h0000_0001_FFFF_FFFD);

    // DIVU 10/3 with start and MTLO injected mid-RUN
    mdOp = 2'b10; mdInA = 32'd10; mdInB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    repeat (5) begin @(posedge clk); e++; end
    #1;
    start = 1'b1; loWe = 1'b1; wrData = 32'h1234; mdOp = 2'b00; mdInA = 32'd5; mdInB = 32'd5;
    @(posedge clk); #1; e++;
    start = 1'b0; loWe = 1'b0;
    check("midrun_lo_held", 64'(loOut), 64'hFFFF_FFFD);
    while (!done && e < 100) begin @(posedge clk); #1; e++; end
    check("midrun_lat", 64'(e), 64'd33);
    check("midrun_hilo", {hiOut, loOut}, 64'h0000_0001_0000_0003);
    @(posedge clk); #1;
    check("midrun_once", {63'd0, busy | done}, 64'd0);
    check("midrun_lo_kept", 64'(loOut), 64'd3);

    // MTLO in IDLE
    loWe = 1'b1; wrData = 32'h1234;
    @(posedge clk); #1;
    loWe = 1'b0;
    check("mtlo", {hiOut, loOut}, 64'h0000_0001_0000_1234);

    // Async reset in the middle of a MULT
    mdOp = 2'b01; mdInA = 32'hFFFF_FFFB; mdInB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy_done", {62'd0, busy, done}, 64'd0);
    check("arst_hilo", {hiOut, loOut}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_idle", {62'd0, busy, done}, 64'd0);
    check("arst_hilo_stay", {hiOut, loOut}, 64'd0);
    do_op(2'b00, 32'd6, 32'd7, lat, bcnt);
    check("post_rst_6x7", {hiOut, loOut}, 64'd42);

    // Back-to-back: second start presented in the done cycle
    do_op(2'b00, 32'd2, 32'd3, lat, bcnt);
    check("b2b_first", {hiOut, loOut, 31'd0, done}, {64'd6, 32'd1});
    do_op(2'b10, 32'd9, 32'd4, lat, bcnt);
    check("b2b_second_lat", 64'(lat), 64'd33);
    check("b2b_second", {hiOut, loOut}, 64'h0000_0001_0000_0002);

    // start together with MTHI in IDLE: MTHI lands, then FIX overwrites
    mdOp = 2'b00; mdInA = 32'd2; mdInB = 32'd2; start = 1'b1; hiWe = 1'b1; wrData = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; hiWe = 1'b0;
    check("start_mthi", 64'(hiOut), 64'hAAAA);
    e = 0;
    while (!done && e < 100) begin @(posedge clk); #1; e++; end
    check("start_mthi_result", {hiOut, loOut}, 64'd4);

    // WIDTH=8 instance
    do_op8(2'b00, 8'd2, 8'd3, lat);
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_mul", {48'd0, hiOut8, loOut8}, 64'h0006);
    do_op8(2'b10, 8'd9, 8'd4, lat);
    check("w8_b2b_lat", 64'(lat), 64'd9);
    check("w8_div", {48'd0, hiOut8, loOut8}, 64'h0102);
    do_op8(2'b01, 8'hFD, 8'd7, lat);
    check("w8_mult_neg", {48'd0, hiOut8, loOut8}, 64'hFFEB);
    do_op8(2'b11, 8'h80, 8'hFF, lat);
    check("w8_div_min", {48'd0, hiOut8, loOut8}, 64'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
